// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: sequential PC generation, redirect handling and a
// small prefetch FIFO feeding decode through a valid/ready handshake.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready,
    output logic        misalign_err,
    output logic [1:0]  fetch_state
);

    localparam int unsigned PW = $clog2(BUF_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        STALL = 2'b10
    } state_t;

    state_t        state, state_next;
    logic [31:0]   fetch_pc;
    logic [31:0]   buf_pc    [BUF_DEPTH];
    logic [31:0]   buf_instr [BUF_DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count, count_next;
    logic          push, pop;
    logic          misalign_q;

    assign imem_addr    = fetch_pc;
    assign out_valid    = (count != '0);
    assign out_pc       = out_valid ? buf_pc[head]    : '0;
    assign out_instr    = out_valid ? buf_instr[head] : '0;
    assign misalign_err = misalign_q;
    assign fetch_state  = state;

    assign pop  = out_valid && out_ready;
    assign push = (state == FETCH) && !redirect_valid && ((count < FULL) || pop);

    // A redirect flushes everything, including an entry popped that same cycle.
    always_comb begin
        count_next = count;
        if (redirect_valid)
            count_next = '0;
        else
            count_next = count + CW'(push) - CW'(pop);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (fetch_en) state_next = FETCH;
            FETCH: begin
                if (!fetch_en)                 state_next = IDLE;
                else if (count_next == FULL)   state_next = STALL;
            end
            STALL: begin
                if (!fetch_en)                 state_next = IDLE;
                else if (count_next < FULL)    state_next = FETCH;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            misalign_q <= 1'b0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            misalign_q <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                head     <= '0;
                tail     <= '0;
            end else begin
                if (push) begin
                    fetch_pc <= fetch_pc + 32'd4;
                    tail     <= tail + PW'(1);
                end
                if (pop)
                    head <= head + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            buf_pc[tail]    <= fetch_pc;
            buf_instr[tail] <= imem_data;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming, stall, redirect, misalign,
// address wrap and mid-stream reset, against hand-computed expectations.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;
    logic        misalign_err;
    logic [1:0]  fetch_state;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] SALT = 32'hA5A5_0000;

    always #5 clk = ~clk;

    assign imem_data = imem_addr ^ SALT;

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .BUF_DEPTH(2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .fetch_en      (fetch_en),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .out_ready     (out_ready),
        .misalign_err  (misalign_err),
        .fetch_state   (fetch_state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        check("rst_valid",    32'(out_valid),    32'h0);
        check("rst_state",    32'(fetch_state),  32'h0);
        check("rst_addr",     imem_addr,         32'h0);
        check("rst_pc",       out_pc,            32'h0);
        check("rst_instr",    out_instr,         32'h0);
        check("rst_misalign", 32'(misalign_err), 32'h0);

        // Streaming with decode always ready
        fetch_en = 1'b1; out_ready = 1'b1;
        step();
        check("str_state", 32'(fetch_state), 32'h1);
        check("str_valid0", 32'(out_valid), 32'h0);
        step();
        check("str_pc0",    out_pc,    32'h0);
        check("str_instr0", out_instr, 32'hA5A5_0000);
        for (int i = 1; i <= 4; i++) begin
            step();
            check("str_pc",    out_pc,    32'(4 * i));
            check("str_instr", out_instr, 32'(4 * i) ^ SALT);
            check("str_addr",  imem_addr, 32'(4 * i + 4));
        end

        // Stall: decode not ready, buffer fills after two pushes
        rst = 1'b1; out_ready = 1'b0;
        step();
        rst = 1'b0;
        step(); step(); step();
        check("stl_state", 32'(fetch_state), 32'h2);
        check("stl_addr",  imem_addr,        32'h8);
        check("stl_pc",    out_pc,           32'h0);
        step();
        check("stl_addr_hold", imem_addr, 32'h8);
        check("stl_pc_hold",   out_pc,    32'h0);
        out_ready = 1'b1;
        step();
        check("stl_resume_pc",    out_pc,           32'h4);
        check("stl_resume_state", 32'(fetch_state), 32'h1);
        out_ready = 1'b0;
        step();
        check("stl_refill_state", 32'(fetch_state), 32'h2);
        check("stl_refill_addr",  imem_addr,        32'hC);
        check("stl_refill_pc",    out_pc,           32'h4);

        // Redirect with buffer holding 0x4 and 0x8; 0x4 accepted, 0x8 dropped
        redirect_valid = 1'b1; redirect_pc = 32'h40; out_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        check("rd_valid",    32'(out_valid),    32'h0);
        check("rd_addr",     imem_addr,         32'h40);
        check("rd_state",    32'(fetch_state),  32'h1);
        check("rd_misalign", 32'(misalign_err), 32'h0);
        step();
        check("rd_pc0",    out_pc,    32'h40);
        check("rd_instr0", out_instr, 32'h40 ^ SALT);
        step();
        check("rd_pc1", out_pc, 32'h44);

        // Misaligned redirect target
        redirect_valid = 1'b1; redirect_pc = 32'h23;
        step();
        redirect_valid = 1'b0;
        check("mis_pulse", 32'(misalign_err), 32'h1);
        check("mis_addr",  imem_addr,         32'h20);
        check("mis_valid", 32'(out_valid),    32'h0);
        step();
        check("mis_clear", 32'(misalign_err), 32'h0);
        check("mis_pc0",   out_pc,            32'h20);
        step();
        check("mis_pc1", out_pc, 32'h24);

        // Address wrap past the top of memory
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect_valid = 1'b0;
        check("wrap_addr",     imem_addr,         32'hFFFF_FFF8);
        check("wrap_misalign", 32'(misalign_err), 32'h0);
        step();
        check("wrap_pc0", out_pc, 32'hFFFF_FFF8);
        step();
        check("wrap_pc1", out_pc, 32'hFFFF_FFFC);
        step();
        check("wrap_pc2",    out_pc,    32'h0000_0000);
        check("wrap_instr2", out_instr, 32'hA5A5_0000);

        // Mid-stream reset with full buffer and a concurrent redirect
        out_ready = 1'b0;
        step();
        check("mrst_full_state", 32'(fetch_state), 32'h2);
        check("mrst_full_valid", 32'(out_valid),   32'h1);
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h81; out_ready = 1'b1;
        step();
        rst = 1'b0; redirect_valid = 1'b0; fetch_en = 1'b0;
        check("mrst_valid",    32'(out_valid),    32'h0);
        check("mrst_addr",     imem_addr,         32'h0);
        check("mrst_state",    32'(fetch_state),  32'h0);
        check("mrst_misalign", 32'(misalign_err), 32'h0);
        check("mrst_pc",       out_pc,            32'h0);
        step();
        check("idle_hold_state", 32'(fetch_state), 32'h0);
        check("idle_hold_addr",  imem_addr,        32'h0);

        // FETCH -> IDLE when fetch_en drops; the push in the last FETCH cycle lands
        out_ready = 1'b0; fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        step();
        check("fi_state", 32'(fetch_state), 32'h0);
        check("fi_valid", 32'(out_valid),   32'h1);
        check("fi_pc",    out_pc,           32'h0);
        step();
        check("fi_addr_hold", imem_addr, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
